// File: rtl/shifter_pkg.sv
// Shared types and helpers for the shared barrel-shifter arbiter.
package shifter_pkg;

    localparam int DATA_W    = 8;
    localparam int AMT_W     = 3;
    localparam int MAX_REQ   = 8;
    localparam int MAX_IDX_W = 3;

    typedef enum logic {
        SHIFT_LEFT  = 1'b0,
        SHIFT_RIGHT = 1'b1
    } shift_dir_e;

    // Output register occupancy: the only state the block keeps.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
    } rr_pick_t;

    // Round-robin search: first asserted bit starting at last+1, wrapping mod n.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0]   valid,
                                         input logic [MAX_IDX_W-1:0] last,
                                         input int                   n);
        rr_pick_t r;
        int       idx;
        r = '0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            if (k <= n) begin
                idx = (int'(last) + k) % n;
                if (!r.found && valid[idx]) begin
                    r.found = 1'b1;
                    r.idx   = idx[MAX_IDX_W-1:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/barrel_shifter.sv
// 8-bit combinational logical barrel shifter, zero fill, no rotate.
module barrel_shifter
    import shifter_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [AMT_W-1:0]  amt,
    input  shift_dir_e        dir,
    output logic [DATA_W-1:0] result
);

    logic [AMT_W:0][DATA_W-1:0] stage;

    assign stage[0] = data;

    // One stage per amount bit; stage gi shifts by 2**gi when that bit is set.
    generate
        for (genvar gi = 0; gi < AMT_W; gi++) begin : g_stage
            assign stage[gi+1] = !amt[gi]            ? stage[gi] :
                                 (dir == SHIFT_LEFT) ? (stage[gi] << (1 << gi)) :
                                                       (stage[gi] >> (1 << gi));
        end
    endgenerate

    assign result = stage[AMT_W];

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker over N request lines.
module rr_arbiter
    import shifter_pkg::*;
#(
    parameter int N    = 4,
    localparam int IW  = (N > 1) ? $clog2(N) : 1
)(
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt_onehot,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    logic [MAX_REQ-1:0]   valid_ext;
    logic [MAX_IDX_W-1:0] last_ext;
    rr_pick_t             pick;

    // Widen to the package's fixed search width, pick, and decode one-hot.
    always_comb begin
        valid_ext           = '0;
        valid_ext[N-1:0]    = valid;
        last_ext            = '0;
        last_ext[IW-1:0]    = last;
        pick                = rr_pick(valid_ext, last_ext, N);
        any                 = pick.found;
        gnt_idx             = pick.idx[IW-1:0];
        gnt_onehot          = '0;
        if (pick.found) begin
            gnt_onehot[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/shifter_arbiter.sv
// Shares one barrel shifter among NUM_REQ valid/ready requesters with a
// round-robin grant and a single registered, ID-tagged result stage.
module shifter_arbiter
    import shifter_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    parameter int  CNT_W   = 16,
    localparam int ID_W    = $clog2(NUM_REQ)
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ*AMT_W-1:0]  req_amt,
    input  logic [NUM_REQ-1:0]        req_dir,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [DATA_W-1:0]         res_data,
    output logic [ID_W-1:0]           res_id,
    output logic [CNT_W-1:0]          op_count
);

    out_state_e          state_reg, state_next;
    logic [DATA_W-1:0]   res_data_reg;
    logic [ID_W-1:0]     res_id_reg;
    logic [ID_W-1:0]     last_gnt_reg;
    logic [CNT_W-1:0]    op_count_reg;

    logic                accept_en;
    logic                grant;
    logic                gnt_any;
    logic [ID_W-1:0]     gnt_idx;
    logic [NUM_REQ-1:0]  gnt_onehot;

    logic [DATA_W-1:0]   data_arr [NUM_REQ];
    logic [AMT_W-1:0]    amt_arr  [NUM_REQ];
    logic [DATA_W-1:0]   sel_data;
    logic [AMT_W-1:0]    sel_amt;
    shift_dir_e          sel_dir;
    logic [DATA_W-1:0]   shift_result;

    // Unpack the flat per-requester operand buses.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
            assign amt_arr[gi]  = req_amt[gi*AMT_W +: AMT_W];
        end
    endgenerate

    // The result slot can take a new op when empty or when it drains this cycle.
    assign accept_en = (state_reg == ST_EMPTY) || res_ready;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .valid      (req_valid),
        .last       (last_gnt_reg),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (gnt_any)
    );

    assign grant     = gnt_any && accept_en;
    assign req_ready = accept_en ? gnt_onehot : '0;

    // Operand mux steering the granted requester into the shared shifter.
    always_comb begin
        sel_data = data_arr[gnt_idx];
        sel_amt  = amt_arr[gnt_idx];
        sel_dir  = req_dir[gnt_idx] ? SHIFT_RIGHT : SHIFT_LEFT;
    end

    barrel_shifter u_shift (
        .data   (sel_data),
        .amt    (sel_amt),
        .dir    (sel_dir),
        .result (shift_result)
    );

    // Occupancy register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Occupancy next state: fill on grant, empty on drain without refill.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_EMPTY: if (grant) state_next = ST_FULL;
            ST_FULL: begin
                if (grant)          state_next = ST_FULL;
                else if (res_ready) state_next = ST_EMPTY;
            end
            default:  state_next = ST_EMPTY;
        endcase
    end

    // Result capture, grant pointer and op counter all advance on a handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_data_reg <= '0;
            res_id_reg   <= '0;
            last_gnt_reg <= ID_W'(NUM_REQ - 1);
            op_count_reg <= '0;
        end else if (grant) begin
            res_data_reg <= shift_result;
            res_id_reg   <= gnt_idx;
            last_gnt_reg <= gnt_idx;
            op_count_reg <= op_count_reg + CNT_W'(1);
        end
    end

    assign res_valid = (state_reg == ST_FULL);
    assign res_data  = res_data_reg;
    assign res_id    = res_id_reg;
    assign op_count  = op_count_reg;

endmodule

// File: tb/tb_shifter_arbiter.sv
// Scoreboard bench for shifter_arbiter (4 requesters, 4-bit counter build).
module tb_shifter_arbiter;

    localparam int NUM_REQ = 4;
    localparam int CNT_W   = 4;
    localparam int ID_W    = 2;

    logic                 clk;
    logic                 rst;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ*3-1:0] req_amt;
    logic [NUM_REQ-1:0]   req_dir;
    logic                 res_valid;
    logic                 res_ready;
    logic [7:0]           res_data;
    logic [ID_W-1:0]      res_id;
    logic [CNT_W-1:0]     op_count;

    typedef struct {
        logic [7:0]      data;
        logic [ID_W-1:0] id;
    } sb_item_t;

    sb_item_t        sb[$];
    int              n_checks = 0;
    int              n_errors = 0;

    logic            m_valid;
    int              m_last;
    logic [CNT_W-1:0] m_cnt;

    shifter_arbiter #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_amt   (req_amt),
        .req_dir   (req_dir),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] shift_model(input logic [7:0] d, input int a, input logic dir);
        logic [7:0] r;
        r = dir ? (d >> a) : (d << a);
        return r;
    endfunction

    // Reference model and scoreboard, evaluated mid-cycle when everything is stable.
    always @(negedge clk) begin
        int         g;
        logic       found;
        logic       accept;
        logic [3:0] exp_ready;
        sb_item_t   it;
        if (rst) begin
            m_valid = 1'b0;
            m_last  = NUM_REQ - 1;
            m_cnt   = '0;
            sb.delete();
        end else begin
            found = 1'b0;
            g     = 0;
            for (int k = 1; k <= NUM_REQ; k++) begin
                if (!found && req_valid[(m_last + k) % NUM_REQ]) begin
                    found = 1'b1;
                    g     = (m_last + k) % NUM_REQ;
                end
            end
            accept    = !m_valid || res_ready;
            exp_ready = (found && accept) ? (4'b0001 << g) : 4'b0000;
            check("req_ready", 32'(req_ready), 32'(exp_ready));
            check("res_valid", 32'(res_valid), 32'(m_valid));
            check("op_count", 32'(op_count), 32'(m_cnt));
            if (m_valid) begin
                if (sb.size() == 0) begin
                    check("sb_empty", 32'(sb.size()), 32'd1);
                end else begin
                    check("res_data", 32'(res_data), 32'(sb[0].data));
                    check("res_id", 32'(res_id), 32'(sb[0].id));
                end
            end
            if (m_valid && res_ready && sb.size() > 0) begin
                void'(sb.pop_front());
            end
            if (found && accept) begin
                it.data = shift_model(req_data[g*8 +: 8], int'(req_amt[g*3 +: 3]), req_dir[g]);
                it.id   = ID_W'(g);
                sb.push_back(it);
                m_valid = 1'b1;
                m_last  = g;
                m_cnt   = m_cnt + 1'b1;
            end else if (res_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic set_req(input int idx, input logic [7:0] d, input int a, input logic dir);
        req_data[idx*8 +: 8] = d;
        req_amt[idx*3 +: 3]  = 3'(a);
        req_dir[idx]         = dir;
        req_valid[idx]       = 1'b1;
    endtask

    // Issue one op from requester idx, wait for its handshake, check the result.
    task automatic single_op(input int idx, input logic [7:0] d, input int a,
                             input logic dir, input logic [7:0] exp);
        bit got;
        got = 1'b0;
        set_req(idx, d, a, dir);
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (req_ready[idx]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("handshake_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        req_valid[idx] = 1'b0;
        check("op_valid", 32'(res_valid), 32'd1);
        check("op_data", 32'(res_data), 32'(exp));
        check("op_id", 32'(res_id), 32'(idx));
        $display("op req%0d data=%02h amt=%0d dir=%0d -> %02h id=%0d", idx, d, a, dir, res_data, res_id);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_amt   = '0;
        req_dir   = '0;
        res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single op held in the register, then async reset mid-cycle.
        single_op(0, 8'hB5, 3, 1'b0, 8'hA8);
        #2 rst = 1'b1;
        #1;
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_data", 32'(res_data), 32'd0);
        check("rst_count", 32'(op_count), 32'd0);
        $display("async reset: valid=%0d data=%02h count=%0d", res_valid, res_data, op_count);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_ready", 32'(req_ready), 32'd0);
        end

        res_ready = 1'b1;
        single_op(2, 8'hB5, 3, 1'b1, 8'h16);

        // Round robin from a fresh pointer.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 8'(8'h11 * (i + 1)), i + 1, i[0]);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            check("rr_valid", 32'(res_valid), 32'd1);
            check("rr_id", 32'(res_id), 32'(k % NUM_REQ));
            $display("rr grant %0d id=%0d data=%02h", k, res_id, res_data);
        end
        check("rr_count", 32'(op_count), 32'd6);

        // Backpressure with requesters 1 and 3 pending; register holds id 1.
        req_valid = '0;
        res_ready = 1'b0;
        set_req(1, 8'h3C, 2, 1'b0);
        set_req(3, 8'hC3, 5, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_ready", 32'(req_ready), 32'd0);
            check("bp_id", 32'(res_id), 32'd1);
            $display("stall %0d id=%0d data=%02h", i, res_id, res_data);
        end
        @(posedge clk);
        #1 res_ready = 1'b1;
        @(posedge clk);
        #1;
        check("resume_valid", 32'(res_valid), 32'd1);
        check("resume_id", 32'(res_id), 32'd3);
        check("resume_data", 32'(res_data), 32'h06);
        @(posedge clk);
        #1;
        check("resume2_id", 32'(res_id), 32'd1);
        check("resume2_data", 32'(res_data), 32'hF0);
        req_valid = '0;

        // Shift amount boundaries.
        single_op(0, 8'h5A, 0, 1'b0, 8'h5A);
        single_op(1, 8'hFF, 7, 1'b0, 8'h80);
        single_op(3, 8'hFF, 7, 1'b1, 8'h01);

        // Counter wrap on the 4-bit build.
        do_reset();
        for (int k = 0; k < 17; k++) begin
            logic [7:0] d;
            d = 8'($urandom_range(0, 255));
            single_op(k % NUM_REQ, d, k % 8, k[0], shift_model(d, k % 8, k[0]));
        end
        check("wrap_count", 32'(op_count), 32'd1);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
